// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage next-PC generator and its BTB.
package pc_pkg;

   localparam logic [1:0] CTR_RESET = 2'b01;
   localparam logic [1:0] CTR_ALLOC = 2'b10;

   typedef enum logic [2:0] {
      NPC_REDIRECT,
      NPC_JUMP,
      NPC_JR,
      NPC_PRED,
      NPC_SEQ
   } npc_sel_e;

   // Entry layout for the default 32-bit PC / 16-entry build; btb_dm mirrors it at its own widths
   localparam int DEF_PC_W  = 32;
   localparam int DEF_IDX_W = 4;

   typedef struct packed {
      logic                            valid;
      logic [DEF_PC_W-DEF_IDX_W-3:0]   tag;
      logic [DEF_PC_W-1:0]             target;
      logic [1:0]                      ctr;
   } btb_entry_t;

   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
      if (taken) return (c == 2'b11) ? c : c + 2'b01;
      else       return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: one combinational lookup port, one clocked training port.
module btb_dm
   import pc_pkg::*;
#(
   parameter int PC_W        = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [PC_W-1:2]   i_rd_pc,
   output logic              o_rd_taken,
   output logic [PC_W-1:0]   o_rd_target,
   input  logic              i_wr_en,
   input  logic [PC_W-1:2]   i_wr_pc,
   input  logic              i_wr_taken,
   input  logic [PC_W-1:0]   i_wr_target
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [PC_W-1:0]   target;
      logic [1:0]        ctr;
   } entry_t;

   entry_t r_btb [BTB_ENTRIES];

   logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
   logic [TAG_W-1:0] w_rd_tag, w_wr_tag;
   entry_t           w_rd_e, w_wr_e;
   logic             w_rd_hit, w_wr_hit;

   assign w_rd_idx = i_rd_pc[IDX_W+1:2];
   assign w_rd_tag = i_rd_pc[PC_W-1:IDX_W+2];
   assign w_wr_idx = i_wr_pc[IDX_W+1:2];
   assign w_wr_tag = i_wr_pc[PC_W-1:IDX_W+2];

   assign w_rd_e   = r_btb[w_rd_idx];
   assign w_wr_e   = r_btb[w_wr_idx];
   assign w_rd_hit = w_rd_e.valid && (w_rd_e.tag == w_rd_tag);
   assign w_wr_hit = w_wr_e.valid && (w_wr_e.tag == w_wr_tag);

   // Lookup reads the flops directly, so a same-cycle update is only seen next cycle
   assign o_rd_taken  = w_rd_hit && w_rd_e.ctr[1];
   assign o_rd_target = w_rd_e.target;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++)
            r_btb[i] <= entry_t'{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end else if (i_wr_en) begin
         if (w_wr_hit) begin
            r_btb[w_wr_idx].ctr <= ctr_next(w_wr_e.ctr, i_wr_taken);
            if (i_wr_taken) r_btb[w_wr_idx].target <= i_wr_target;
         end else if (i_wr_taken) begin
            r_btb[w_wr_idx] <= entry_t'{valid: 1'b1, tag: w_wr_tag,
                                        target: i_wr_target, ctr: CTR_ALLOC};
         end
      end
   end

endmodule

// File: rtl/pc_predict_if.sv
// IF-stage next-PC generator: PC register, redirect/jump/predict priority mux, optional BTB.
module pc_predict_if
   import pc_pkg::*;
#(
   parameter int              PC_W        = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter bit              BTB_EN      = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_pc_enable,
   input  logic             i_jump,
   input  logic [25:0]      i_jea,
   input  logic             i_jump_register,
   input  logic [PC_W-1:0]  i_rs_data,
   input  logic             i_ex_mispredict,
   input  logic [PC_W-1:0]  i_ex_correct_pc,
   input  logic             i_ex_update,
   input  logic [PC_W-1:0]  i_ex_pc,
   input  logic             i_ex_taken,
   input  logic [PC_W-1:0]  i_ex_target,
   output logic [PC_W-1:0]  o_pc,
   output logic             o_pred_taken
);

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc4, w_npc, w_pred_target;
   logic            w_pred_taken;
   npc_sel_e        w_sel;

   assign w_pc4 = r_pc + PC_W'(4);

   generate
      if (BTB_EN) begin : g_btb
         logic w_unused;
         assign w_unused = ^i_ex_pc[1:0];

         btb_dm #(
            .PC_W        (PC_W),
            .BTB_ENTRIES (BTB_ENTRIES)
         ) u_btb (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_rd_pc     (r_pc[PC_W-1:2]),
            .o_rd_taken  (w_pred_taken),
            .o_rd_target (w_pred_target),
            .i_wr_en     (i_ex_update),
            .i_wr_pc     (i_ex_pc[PC_W-1:2]),
            .i_wr_taken  (i_ex_taken),
            .i_wr_target (i_ex_target)
         );
      end else begin : g_no_btb
         logic w_unused;
         assign w_unused      = ^{i_ex_update, i_ex_pc, i_ex_taken, i_ex_target};
         assign w_pred_taken  = 1'b0;
         assign w_pred_target = '0;
      end
   endgenerate

   // A mispredict redirect wins over everything, including a stall
   always_comb begin
      w_sel = NPC_SEQ;
      if (i_ex_mispredict)      w_sel = NPC_REDIRECT;
      else if (i_jump)          w_sel = NPC_JUMP;
      else if (i_jump_register) w_sel = NPC_JR;
      else if (w_pred_taken)    w_sel = NPC_PRED;
   end

   always_comb begin
      w_npc = w_pc4;
      unique case (w_sel)
         NPC_REDIRECT: w_npc = i_ex_correct_pc;
         NPC_JUMP:     w_npc = {w_pc4[PC_W-1:28], i_jea, 2'b00};
         NPC_JR:       w_npc = i_rs_data;
         NPC_PRED:     w_npc = w_pred_target;
         default:      w_npc = w_pc4;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                          r_pc <= RESET_PC;
      else if (i_ex_mispredict || i_pc_enable) r_pc <= w_npc;
   end

   assign o_pc         = r_pc;
   assign o_pred_taken = w_pred_taken;

endmodule

// File: tb/tb_pc_predict_if.sv
// Directed vector bench for pc_predict_if; a second instance runs with the BTB removed.
module tb_pc_predict_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_enable, jump, jump_register, ex_mispredict, ex_update, ex_taken;
   logic [25:0] jea;
   logic [31:0] rs_data, ex_correct_pc, ex_pc, ex_target;
   logic [31:0] pc, pc_nb;
   logic        pred, pred_nb;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_predict_if #(.PC_W(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .BTB_EN(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pc_enable(pc_enable), .i_jump(jump), .i_jea(jea),
      .i_jump_register(jump_register), .i_rs_data(rs_data),
      .i_ex_mispredict(ex_mispredict), .i_ex_correct_pc(ex_correct_pc),
      .i_ex_update(ex_update), .i_ex_pc(ex_pc), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
      .o_pc(pc), .o_pred_taken(pred));

   pc_predict_if #(.PC_W(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .BTB_EN(1'b0)) dut_nb (
      .i_clk(clk), .i_rst_n(rst_n), .i_pc_enable(pc_enable), .i_jump(jump), .i_jea(jea),
      .i_jump_register(jump_register), .i_rs_data(rs_data),
      .i_ex_mispredict(ex_mispredict), .i_ex_correct_pc(ex_correct_pc),
      .i_ex_update(ex_update), .i_ex_pc(ex_pc), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
      .o_pc(pc_nb), .o_pred_taken(pred_nb));

   typedef struct {
      logic        en, j;
      logic [25:0] jea;
      logic        jr;
      logic [31:0] rs;
      logic        mis;
      logic [31:0] cpc;
      logic        upd;
      logic [31:0] epc;
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] pc_nb;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void add(input logic en, input logic j, input logic [25:0] ja,
                               input logic jr, input logic [31:0] rs,
                               input logic mis, input logic [31:0] cpc,
                               input logic upd, input logic [31:0] epc, input logic tk,
                               input logic [31:0] tgt, input logic [31:0] epcv,
                               input logic epred, input logic [31:0] epc_nb);
      vec_t v;
      v.en = en; v.j = j; v.jea = ja; v.jr = jr; v.rs = rs; v.mis = mis; v.cpc = cpc;
      v.upd = upd; v.epc = epc; v.tk = tk; v.tgt = tgt;
      v.pc = epcv; v.pred = epred; v.pc_nb = epc_nb;
      vq.push_back(v);
   endfunction

   // Idle fetch, redirect, and redirect-with-training shorthands
   function automatic void idle(input logic [31:0] p, input logic pr, input logic [31:0] pnb);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, p, pr, pnb);
   endfunction
   function automatic void redir(input logic [31:0] c, input logic pr);
      add(1, 0, 0, 0, 0, 1, c, 0, 0, 0, 0, c, pr, c);
   endfunction
   function automatic void redir_tr(input logic [31:0] c, input logic [31:0] epc,
                                    input logic tk, input logic [31:0] tgt, input logic pr);
      add(1, 0, 0, 0, 0, 1, c, 1, epc, tk, tgt, c, pr, c);
   endfunction

   task automatic drive(input vec_t v);
      pc_enable = v.en; jump = v.j; jea = v.jea; jump_register = v.jr; rs_data = v.rs;
      ex_mispredict = v.mis; ex_correct_pc = v.cpc;
      ex_update = v.upd; ex_pc = v.epc; ex_taken = v.tk; ex_target = v.tgt;
   endtask

   task automatic clear_in();
      vec_t v;
      v = '{default: '0};
      drive(v);
   endtask

   task automatic step_chk(input vec_t v, input string tag);
      drive(v);
      @(posedge clk); #1;
      chk({tag, " pc"}, pc, v.pc);
      chk({tag, " pred"}, {31'b0, pred}, {31'b0, v.pred});
      chk({tag, " pc_nobtb"}, pc_nb, v.pc_nb);
      chk({tag, " pred_nobtb"}, {31'b0, pred_nb}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      clear_in();

      // sequential fetch
      idle(32'h4, 0, 32'h4); idle(32'h8, 0, 32'h8); idle(32'hC, 0, 32'hC); idle(32'h10, 0, 32'h10);
      // jump beats jr; jr alone; jump keeps pc4 upper bits; wrap to zero
      redir(32'h0040_0000, 0);
      add(1, 1, 26'h10, 1, 32'h500, 0, 0, 0, 0, 0, 0, 32'h40, 0, 32'h40);
      add(1, 0, 0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 32'h500, 0, 32'h500);
      redir(32'hF000_0000, 0);
      add(1, 1, 26'h3FF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
      idle(32'h0, 0, 32'h0);
      redir(32'hEFFF_FFFC, 0);
      add(1, 1, 26'h1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hF000_0004, 0, 32'hF000_0004);
      // learn 0x8 -> 0x100 (redirect and update together)
      redir_tr(32'h0, 32'h8, 1, 32'h100, 0);
      idle(32'h4, 0, 32'h4); idle(32'h8, 1, 32'h8); idle(32'h100, 0, 32'hC);
      redir_tr(32'h8, 32'h8, 0, 0, 0);
      idle(32'hC, 0, 32'hC);
      // same-cycle lookup sees old entry
      redir_tr(32'h8, 32'h8, 1, 32'h100, 1);
      add(1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 0, 32'h100, 0, 32'hC);
      redir(32'h8, 0);
      idle(32'hC, 0, 32'hC);
      // counter saturation at 11, target refresh, saturation at 00
      redir_tr(32'h8, 32'h8, 1, 32'h100, 1);
      redir_tr(32'h8, 32'h8, 1, 32'h100, 1);
      redir_tr(32'h8, 32'h8, 1, 32'h100, 1);
      redir_tr(32'h8, 32'h8, 0, 0, 1);
      redir_tr(32'h8, 32'h8, 0, 0, 0);
      redir_tr(32'h8, 32'h8, 1, 32'h300, 1);
      idle(32'h300, 0, 32'hC);
      redir_tr(32'h8, 32'h8, 0, 0, 0);
      redir_tr(32'h8, 32'h8, 0, 0, 0);
      redir_tr(32'h8, 32'h8, 0, 0, 0);
      redir_tr(32'h8, 32'h8, 1, 32'h300, 0);
      redir_tr(32'h8, 32'h8, 1, 32'h300, 1);
      // redirect during stall, then hold with jump asserted
      add(0, 1, 26'h5, 0, 0, 1, 32'h200, 0, 0, 0, 0, 32'h200, 0, 32'h200);
      add(0, 1, 26'h5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 32'h200);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 32'h200);
      idle(32'h204, 0, 32'h204);
      // aliasing on idx 2, overwrite by alias, miss not-taken leaves entry alone
      redir(32'h48, 0);
      idle(32'h4C, 0, 32'h4C);
      redir_tr(32'h8, 32'h48, 1, 32'h500, 0);
      idle(32'hC, 0, 32'hC);
      redir(32'h48, 1);
      idle(32'h500, 0, 32'h4C);
      redir_tr(32'h48, 32'h88, 0, 0, 1);
      redir(32'h48, 1);

      #2;
      chk("reset pc", pc, 32'h0);
      chk("reset pred", {31'b0, pred}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vq[i]) step_chk(vq[i], $sformatf("vec%0d", i));

      // mid-run reset discards a pending redirect and update
      redir(32'h3C, 0);
      step_chk(vq[vq.size()-1], "pre_reset");
      ex_mispredict = 1'b1; ex_correct_pc = 32'h200;
      ex_update = 1'b1; ex_pc = 32'h3C; ex_taken = 1'b1; ex_target = 32'h80;
      rst_n = 1'b0;
      #1;
      chk("async reset pc", pc, 32'h0);
      chk("async reset pred", {31'b0, pred}, 32'h0);
      @(posedge clk); #1;
      chk("reset hold pc", pc, 32'h0);
      chk("reset hold pc_nobtb", pc_nb, 32'h0);
      clear_in();
      rst_n = 1'b1;
      vq.delete();
      idle(32'h4, 0, 32'h4);
      redir(32'h48, 0);
      redir(32'h3C, 0);
      idle(32'h40, 0, 32'h40);
      foreach (vq[i]) step_chk(vq[i], $sformatf("post_reset%0d", i));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
